uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin scheduler that shares one UART transmitter among N byte requesters.
//  Each requester offers a byte with a valid/ready handshake; the arbiter grants one,
//  latches its byte, pulses the transmitter enable, then waits for the frame-done pulse.
//  A watchdog recovers from a missing done pulse. Sits between producer blocks and the UART TX core.
// PARAMETERS
//  N_REQ        4     number of requesters (>=2)
//  D_BITS       8     data bits per frame; must match the transmitter
//  TIMEOUT_CYC  4096  max i_clk cycles in WAIT before abort; 0 disables watchdog
// PORTS
//  i_clk         in   1             system clock, rising edge
//  i_rst_n       in   1             asynchronous, active-low reset
//  i_req_valid   in   N_REQ         per-requester byte valid
//  i_req_data    in   N_REQ*D_BITS  requester k byte at [k*D_BITS +: D_BITS]
//  o_req_ready   out  N_REQ         one-hot accept; transfer when valid&&ready
//  o_tx_data     out  D_BITS        byte to transmitter (registered)
//  o_tx_enable   out  1             one-cycle start pulse to transmitter
//  i_tx_done     in   1             one-cycle frame-complete pulse from transmitter
//  o_busy        out  1             high in ISSUE or WAIT
//  o_grant_id    out  $clog2(N_REQ) index of last granted requester (registered)
//  o_timeout     out  1             one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE, o_tx_data=0, o_grant_id=N_REQ-1, rr pointer=N_REQ-1, timer=0;
//   o_req_ready=0, o_tx_enable=0, o_busy=0, o_timeout=0. Reset is honoured in any state.
//  FSM states: IDLE, ISSUE, WAIT.
//  IDLE: if any i_req_valid, winner = first valid index searching ptr+1, ptr+2, ...
//   mod N_REQ. Combinationally assert o_req_ready[winner] only; at the clock edge latch
//   o_tx_data<=winner byte, ptr<=winner, o_grant_id<=winner, ->ISSUE.
//   If no valid, stay in IDLE.
//  o_req_ready depends only on state and i_req_valid, never on i_req_data.
//   It is zero outside IDLE.
//  ISSUE: o_tx_enable=1 for exactly this cycle, o_tx_data stable; timer<=0; ->WAIT.
//  WAIT: timer increments each cycle.
//   On i_tx_done: ->IDLE. New grant possible the next cycle.
//   Else if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1: o_timeout=1 for one cycle, ->IDLE.
//   If i_tx_done and the timeout coincide, done wins and o_timeout stays 0.
//   i_tx_done in IDLE or ISSUE is ignored.
//  o_tx_data holds its value outside the latch edge; the transmitter may sample it any time.
//  Throughput: grant→enable 1 cycle; done→next ready 1 cycle; <=2 idle cycles per frame.
//  Fairness: a continuously valid requester waits at most N_REQ-1 frames.
//  The pointer advances only on grant.
//  Limitation: the transmitter has no reset. Reset mid-frame may pair a stale done with the next grant.
//   The system must hold i_rst_n until the line is idle.
//  Unknown index bits: if N_REQ is not a power of 2, unused o_grant_id codes never occur.
// TESTING
//  1 Single req0 valid, data 8'hA5 -> ready[0] 1 cycle; o_tx_enable next cycle; o_tx_data=A5; busy until done.
//  2 All 4 valid continuously after reset -> grant order 0,1,2,3,0; grant_id follows; one frame each.
//  3 req1 and req3 valid, ptr=1 -> req3 granted first, then req1; req2 never readied.
//  4 Withhold i_tx_done, TIMEOUT_CYC=16 -> o_timeout pulse 16 cycles after enable; IDLE; next grant proceeds.
//  5 i_tx_done on the timeout cycle -> no o_timeout; normal return to IDLE.
//  6 Assert i_rst_n=0 during WAIT -> all outputs reset immediately; after release req0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte
// requesters. Grants one valid requester, latches its byte, pulses the
// transmitter enable, then waits for frame-done with a watchdog fallback.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int D_BITS      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*D_BITS-1:0]  i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [D_BITS-1:0]        o_tx_data,
    output logic                     o_tx_enable,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_timeout
);

    localparam int IW = $clog2(N_REQ);
    // Timer only has to reach TIMEOUT_CYC-1; with the watchdog off it just wraps.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [TW-1:0]   r_timer;
    logic [D_BITS-1:0] r_tx_data;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_cand;
    int              w_idx;

    // Rotating priority search: first valid starting just after the last grant.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            w_cand = IW'(w_idx);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and handshake/strobe outputs; ready never looks at data.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_tx_enable = 1'b0;
        o_busy      = 1'b0;
        o_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    o_req_ready[w_win] = 1'b1;
                    w_state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_tx_enable = 1'b1;
                o_busy      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                // Done takes priority over a coincident watchdog expiry.
                if (i_tx_done) begin
                    w_state_nxt = S_IDLE;
                end else if (TIMEOUT_CYC != 0 && r_timer == TLAST) begin
                    o_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch winner byte and pointer on the grant edge only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_data <= '0;
            r_ptr     <= IW'(N_REQ - 1);
        end else if (r_state == S_IDLE && w_found) begin
            r_tx_data <= i_req_data[w_win*D_BITS +: D_BITS];
            r_ptr     <= w_win;
        end
    end

    // Watchdog timer: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_timer <= '0;
        else if (r_state == S_ISSUE) r_timer <= '0;
        else if (r_state == S_WAIT)  r_timer <= r_timer + 1'b1;
    end

    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle on
// the falling edge, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DB-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [DB-1:0]   tx_data;
    logic            tx_en;
    logic            tx_done;
    logic            busy;
    logic [1:0]      grant_id;
    logic            tout;

    uart_tx_arbiter #(.N_REQ(NR), .D_BITS(DB), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_tx_data(tx_data), .o_tx_enable(tx_en),
        .i_tx_done(tx_done), .o_busy(busy), .o_grant_id(grant_id), .o_timeout(tout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Environment state: requester byte counts/data, transmitter latency.
    int        pend[NR];
    logic [7:0] dat[NR];
    int        tx_lat;
    int        cnt = 0;
    logic [NR-1:0] acc_seen = '0;
    logic      en_seen = 1'b0;

    // Event records.
    int log_q[$];
    int log_cyc[$];
    int cyc = 0;
    int en_cyc = 0, en_cnt = 0;
    int to_cyc = 0, to_cnt = 0;
    int done_cyc = 0;
    int rdy_cnt[NR];

    // Model: last granted index, latched byte, cycles since enable (-1 = idle).
    int        m_ptr = NR - 1;
    logic [7:0] m_data = 8'h00;
    int        m_since = -1;

    function automatic int pick();
        for (int s = 1; s <= NR; s++) begin
            if (req_valid[(m_ptr + s) % NR]) return (m_ptr + s) % NR;
        end
        return -1;
    endfunction

    // Requesters and transmitter, driven 2 time units after the rising edge.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            tx_done = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (acc_seen[k] && pend[k] > 0) begin
                    pend[k]--;
                    dat[k] = dat[k] + 8'd1;
                end
            end
            acc_seen = '0;
            if (!rst_n) cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_done = 1'b1;
            end
            if (en_seen && rst_n) cnt = tx_lat;
            en_seen = 1'b0;
            for (int k = 0; k < NR; k++) begin
                req_valid[k] = (pend[k] != 0);
                req_data[k*DB +: DB] = dat[k];
            end
        end
    end

    // Compare process: model expectations vs DUT every falling edge.
    always @(negedge clk) begin
        logic [NR-1:0] e_ready;
        logic e_en, e_busy, e_to;
        int w;
        if (!rst_n) begin
            m_ptr = NR - 1; m_data = 8'h00; m_since = -1;
        end
        e_ready = '0; e_en = 1'b0; e_busy = 1'b0; e_to = 1'b0; w = -1;
        if (m_since < 0) begin
            if (rst_n) w = pick();
            if (w >= 0) e_ready[w] = 1'b1;
        end else if (m_since == 0) begin
            e_en = 1'b1; e_busy = 1'b1;
        end else begin
            e_busy = 1'b1;
            e_to = !tx_done && (m_since == TO);
        end
        chk("ready", 32'(req_ready), 32'(e_ready));
        chk("tx_enable", 32'(tx_en), 32'(e_en));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("timeout", 32'(tout), 32'(e_to));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_ptr));
        if (rst_n) begin
            for (int k = 0; k < NR; k++) begin
                if (req_ready[k]) rdy_cnt[k]++;
                if (req_ready[k] && req_valid[k]) begin
                    log_q.push_back(k);
                    log_cyc.push_back(cyc);
                end
            end
            acc_seen = req_ready & req_valid;
            if (tx_en) begin en_cyc = cyc; en_cnt++; en_seen = 1'b1; end
            if (tout) begin to_cyc = cyc; to_cnt++; end
            if (tx_done && busy) done_cyc = cyc;
            if (m_since < 0) begin
                if (w >= 0) begin
                    m_ptr = w; m_data = req_data[w*DB +: DB]; m_since = 0;
                end
            end else if (m_since == 0) begin
                m_since = 1;
            end else if (tx_done || m_since == TO) begin
                m_since = -1;
            end else begin
                m_since++;
            end
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            ok = (pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0 && !busy);
        end
        if (!ok) begin
            bad++;
            $display("FAIL %s timeout waiting for idle (actual busy, required idle)", nm);
        end
    endtask

    task automatic wait_log(input string nm, input int n, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step(1);
            ok = (log_q.size() >= n);
        end
        if (!ok) begin
            bad++;
            $display("FAIL %s grants=%0d required=%0d", nm, log_q.size(), n);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_lat = 3;
        for (int k = 0; k < NR; k++) begin pend[k] = 0; dat[k] = 8'(k << 4); rdy_cnt[k] = 0; end
        req_valid = '0; req_data = '0;
        step(3);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;

        // 1: single requester 0 with A5.
        dat[0] = 8'hA5; pend[0] = 1;
        wait_idle("t1", 100);
        chk("t1_ngrant", log_q.size(), 1);
        chk("t1_id", log_q[0], 0);
        chk("t1_ready_cycles", rdy_cnt[0], 1);
        chk("t1_en_count", en_cnt, 1);
        chk("t1_en_latency", en_cyc - log_cyc[0], 1);
        chk("t1_data", 32'(tx_data), 32'hA5);

        // 2: all continuously valid after reset.
        pulse_reset();
        log_q.delete(); log_cyc.delete();
        for (int k = 0; k < NR; k++) begin dat[k] = 8'(k << 4); pend[k] = 100; end
        wait_log("t2_wait", 5, 200);
        for (int k = 0; k < NR; k++) pend[k] = 0;
        wait_idle("t2", 100);
        chk("t2_g0", log_q[0], 0);
        chk("t2_g1", log_q[1], 1);
        chk("t2_g2", log_q[2], 2);
        chk("t2_g3", log_q[3], 3);
        chk("t2_g4", log_q[4], 0);
        chk("t2_period", log_cyc[1] - log_cyc[0], tx_lat + 3);

        // 3: ptr=1, requesters 1 and 3.
        pulse_reset();
        log_q.delete(); log_cyc.delete();
        pend[1] = 1;
        wait_idle("t3a", 100);
        chk("t3_ptr", 32'(grant_id), 32'd1);
        log_q.delete(); rdy_cnt[2] = 0;
        pend[1] = 1; pend[3] = 1;
        wait_idle("t3b", 100);
        chk("t3_ngrant", log_q.size(), 2);
        chk("t3_first", log_q[0], 3);
        chk("t3_second", log_q[1], 1);
        chk("t3_req2_ready", rdy_cnt[2], 0);

        // 4: missing done -> watchdog.
        tx_lat = 0; to_cnt = 0; log_q.delete();
        pend[0] = 1;
        wait_idle("t4", 100);
        chk("t4_to_count", to_cnt, 1);
        chk("t4_to_delay", to_cyc - en_cyc, 16);
        tx_lat = 3;
        pend[2] = 1;
        wait_idle("t4b", 100);
        chk("t4_next_grant", log_q[log_q.size()-1], 2);
        chk("t4_to_count2", to_cnt, 1);

        // 5: done coincides with watchdog expiry.
        tx_lat = 15;
        pend[1] = 1;
        wait_idle("t5", 100);
        chk("t5_done_delay", done_cyc - en_cyc, 16);
        chk("t5_to_count", to_cnt, 1);
        chk("t5_grant", 32'(grant_id), 32'd1);

        // 6: reset during WAIT.
        tx_lat = 0;
        pend[2] = 1;
        step(6);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_grant_id", 32'(grant_id), 32'd3);
        chk("t6_tx_data", 32'(tx_data), 32'd0);
        step(2);
        rst_n = 1'b1;
        tx_lat = 3;
        log_q.delete();
        pend[0] = 1; pend[1] = 1;
        wait_idle("t6", 100);
        chk("t6_first", log_q[0], 0);
        chk("t6_second", log_q[1], 1);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
